// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Operands are latched at launch, and the result is committed when the countdown expires.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    r_state, w_stateNext;
  logic [CW-1:0]             r_count, w_countNext;
  logic [2:0]                r_op;
  logic [WIDTH-1:0]          r_a, r_b, r_hi, r_lo;
  logic [WIDTH-1:0]          w_hiNext, w_loNext, w_resHi, w_resLo;
  logic                      w_capture;
  logic [2*WIDTH-1:0]        w_uprod;
  logic signed [2*WIDTH-1:0] w_sprod;
  logic signed [WIDTH-1:0]   w_sa, w_sb, w_squot, w_srem;

  assign w_uprod = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
  assign w_sprod = $signed({{WIDTH{r_a[WIDTH-1]}}, r_a}) * $signed({{WIDTH{r_b[WIDTH-1]}}, r_b});
  assign w_sa    = $signed(r_a);
  assign w_sb    = $signed(r_b);
  assign w_squot = w_sa / w_sb;
  assign w_srem  = w_sa % w_sb;

  // Zero divisor and the signed overflow case are steered away from the dividers.
  always_comb begin
    w_resHi = '0;
    w_resLo = '0;
    case (r_op)
      3'd0: {w_resHi, w_resLo} = w_uprod;
      3'd1: {w_resHi, w_resLo} = w_sprod;
      3'd2: begin
        if (r_b == '0) begin
          w_resLo = '1;
          w_resHi = r_a;
        end else begin
          w_resLo = r_a / r_b;
          w_resHi = r_a % r_b;
        end
      end
      3'd3: begin
        if (r_b == '0) begin
          w_resLo = '1;
          w_resHi = r_a;
        end else if (r_a == MIN_NEG && r_b == '1) begin
          w_resLo = MIN_NEG;
          w_resHi = '0;
        end else begin
          w_resLo = w_squot;
          w_resHi = w_srem;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_stateNext = r_state;
    w_countNext = r_count;
    w_hiNext    = r_hi;
    w_loNext    = r_lo;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          case (op)
            3'd0, 3'd1: begin
              w_capture   = 1'b1;
              w_stateNext = RUN;
              w_countNext = CW'(MULT_CYCLES);
            end
            3'd2, 3'd3: begin
              w_capture   = 1'b1;
              w_stateNext = RUN;
              w_countNext = CW'(DIV_CYCLES);
            end
            3'd4:    w_hiNext = rs_data;
            3'd5:    w_loNext = rs_data;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (r_count == CW'(1)) begin
          w_stateNext = IDLE;
          w_hiNext    = w_resHi;
          w_loNext    = w_resLo;
        end else begin
          w_countNext = r_count - CW'(1);
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_count <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_stateNext;
      r_count <= w_countNext;
      r_hi    <= w_hiNext;
      r_lo    <= w_loNext;
      if (w_capture) begin
        r_op <= op;
        r_a  <= rs_data;
        r_b  <= rt_data;
      end
    end
  end

  assign busy = (r_state == RUN);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Randomized bench for md_unit: a cycle-time reference model, one per-cycle compare process,
// and literal checks on the documented scenarios.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        busy;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference model: the result lands at an absolute cycle number.
  logic [31:0] mHi, mLo, pHi, pLo;
  logic        pending;
  int          cyc, doneCyc;

  function automatic void calc(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] h, output logic [31:0] l);
    longint unsigned ua, ub, up;
    longint sa, sb, sp, q, r;
    ua = a; ub = b;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    h = '0; l = '0;
    case (o)
      3'd0: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
      3'd1: begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; end
      3'd2: if (b == 0) begin l = 32'hFFFF_FFFF; h = a; end
            else begin l = a / b; h = a % b; end
      3'd3: if (b == 0) begin l = 32'hFFFF_FFFF; h = a; end
            else begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
      default: ;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mHi = '0; mLo = '0; pending = 1'b0; cyc = 0; doneCyc = 0;
    end else begin
      cyc = cyc + 1;
      if (pending) begin
        if (cyc == doneCyc) begin
          mHi = pHi; mLo = pLo; pending = 1'b0;
        end
      end else if (start) begin
        case (op)
          3'd0, 3'd1, 3'd2, 3'd3: begin
            calc(op, rs_data, rt_data, pHi, pLo);
            pending = 1'b1;
            doneCyc = cyc + ((op < 3'd2) ? 5 : 10);
          end
          3'd4: mHi = rs_data;
          3'd5: mLo = rs_data;
          default: ;
        endcase
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (reset === 1'b1) begin
      checkOutput("model busy", {31'b0, busy}, {31'b0, pending});
      checkOutput("model hi", hi, mHi);
      checkOutput("model lo", lo, mLo);
    end
  end

  task automatic applyStimulus(input logic st, input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b);
    @(negedge clk);
    start = st; op = o; rs_data = a; rt_data = b;
  endtask

  // Launches one op, scrambles operands while it runs, and returns the busy cycle count.
  task automatic runOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int cycles);
    applyStimulus(1'b1, o, a, b);
    applyStimulus(1'b0, 3'($urandom), $urandom, $urandom);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    if (cycles >= 100) begin
      miscompares++;
      $display("[TB] FAIL busy timeout: got stuck busy, expected idle");
    end
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; op = '0; rs_data = '0; rt_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset hi", hi, 32'd0);
    checkOutput("reset lo", lo, 32'd0);
    reset = 1'b1;

    runOp(3'd0, 32'hFFFF_FFFF, 32'h2, n);
    checkOutput("multu latency", n, 32'd5);
    checkOutput("multu hi", hi, 32'h1);
    checkOutput("multu lo", lo, 32'hFFFF_FFFE);

    runOp(3'd1, 32'hFFFF_FFFD, 32'h7, n);
    checkOutput("mult hi", hi, 32'hFFFF_FFFF);
    checkOutput("mult lo", lo, 32'hFFFF_FFEB);

    runOp(3'd3, 32'hFFFF_FFF9, 32'h2, n);
    checkOutput("div latency", n, 32'd10);
    checkOutput("div lo", lo, 32'hFFFF_FFFD);
    checkOutput("div hi", hi, 32'hFFFF_FFFF);

    runOp(3'd2, 32'd100, 32'd7, n);
    checkOutput("divu lo", lo, 32'd14);
    checkOutput("divu hi", hi, 32'd2);

    runOp(3'd2, 32'h1234, 32'h0, n);
    checkOutput("divu0 lo", lo, 32'hFFFF_FFFF);
    checkOutput("divu0 hi", hi, 32'h1234);

    runOp(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
    checkOutput("divovf lo", lo, 32'h8000_0000);
    checkOutput("divovf hi", hi, 32'h0);

    applyStimulus(1'b1, 3'd2, 32'd9, 32'd2);
    applyStimulus(1'b1, 3'd4, 32'hDEAD, 32'h3);
    applyStimulus(1'b1, 3'd5, 32'hBEEF, 32'h5);
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
    n = 0;
    while (busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
    checkOutput("ignored lo", lo, 32'd4);
    checkOutput("ignored hi", hi, 32'd1);
    applyStimulus(1'b1, 3'd5, 32'hCAFE, 32'h0);
    applyStimulus(1'b0, 3'd7, 32'h0, 32'h0);
    checkOutput("mtlo lo", lo, 32'hCAFE);
    checkOutput("mtlo hi", hi, 32'd1);
    checkOutput("mtlo busy", {31'b0, busy}, 32'd0);

    applyStimulus(1'b1, 3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("abort busy", {31'b0, busy}, 32'd0);
    checkOutput("abort hi", hi, 32'd0);
    checkOutput("abort lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("no late hi", hi, 32'd0);
    checkOutput("no late lo", lo, 32'd0);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 3'($urandom), pickOperand(), pickOperand());
    end
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
    n = 0;
    while (busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
    if (n >= 100) begin
      miscompares++;
      $display("[TB] FAIL final drain: got busy, expected idle");
    end
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
